// File: rtl/spi_reg_bank.sv
// Command/address decoder behind the SPI slave receiver: fills a shadow register bank
// byte by byte and commits it atomically to the active bank when chip-select drops.
module spi_reg_bank #(
    parameter int NUM_REGS = 16
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [7:0]            data_in,
    input  logic                  data_valid_in,
    input  logic                  transaction_valid_in,
    output logic [NUM_REGS*8-1:0] regs_out,
    output logic                  update_out,
    output logic                  busy_out,
    output logic                  addr_err_out
);

    localparam int BANK_W = NUM_REGS * 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [6:0]        ptr_q, ptr_d;
    logic              autoinc_q, autoinc_d;
    logic              dirty_q, dirty_d;
    logic              addr_err_q, addr_err_d;
    logic              update_q, update_d;
    logic [BANK_W-1:0] shadow_q, shadow_d;
    logic [BANK_W-1:0] active_q, active_d;
    logic              ptr_in_range;
    logic              txn_end;

    // The pointer spans the full 7-bit space; only the first NUM_REGS addresses exist.
    assign ptr_in_range = ({1'b0, ptr_q} < 8'(NUM_REGS));
    assign txn_end      = (state_q != IDLE) && !transaction_valid_in;

    // NOTE: every variable gets its hold value first, so no path through the
    // branches below leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        autoinc_d  = autoinc_q;
        dirty_d    = dirty_q;
        addr_err_d = addr_err_q;
        update_d   = 1'b0;
        shadow_d   = shadow_q;
        active_d   = active_q;

        if (txn_end) begin
            // Chip-select dropped: any byte strobed in this same cycle is discarded.
            if (dirty_q) begin
                active_d = shadow_q;
                update_d = 1'b1;
            end
            dirty_d = 1'b0;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (transaction_valid_in) begin
                        addr_err_d = 1'b0;
                        state_d    = CMD;
                    end
                end
                CMD: begin
                    if (data_valid_in) begin
                        ptr_d     = data_in[6:0];
                        autoinc_d = data_in[7];
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    if (data_valid_in) begin
                        if (ptr_in_range) begin
                            for (int k = 0; k < NUM_REGS; k++) begin
                                if (ptr_q == 7'(k)) begin
                                    shadow_d[k*8 +: 8] = data_in;
                                end
                            end
                            dirty_d = 1'b1;
                        end else begin
                            addr_err_d = 1'b1;
                        end
                        if (autoinc_q) begin
                            ptr_d = ptr_q + 7'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q    <= IDLE;
            ptr_q      <= 7'd0;
            autoinc_q  <= 1'b0;
            dirty_q    <= 1'b0;
            addr_err_q <= 1'b0;
            update_q   <= 1'b0;
            // NOTE: both banks are reset because the tone generator reads the
            // active bank directly and the shadow must mirror it after reset.
            shadow_q   <= '0;
            active_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            autoinc_q  <= autoinc_d;
            dirty_q    <= dirty_d;
            addr_err_q <= addr_err_d;
            update_q   <= update_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
        end
    end

    assign regs_out     = active_q;
    assign update_out   = update_q;
    assign busy_out     = (state_q != IDLE);
    assign addr_err_out = addr_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: a 16-register and a 128-register instance share
// the stimulus; each scenario checks the instance it targets against hand values.
module tb_spi_reg_bank;

    logic          clk_in;
    logic          reset_in;
    logic [7:0]    data_in;
    logic          data_valid_in;
    logic          transaction_valid_in;

    logic [127:0]  a_regs;
    logic          a_upd;
    logic          a_busy;
    logic          a_err;

    logic [1023:0] b_regs;
    logic          b_upd;
    logic          b_busy;
    logic          b_err;

    logic [127:0]  exp_a;
    int            checks   = 0;
    int            failures = 0;

    spi_reg_bank #(.NUM_REGS(16)) dut_a (
        .clk_in               (clk_in),
        .reset_in             (reset_in),
        .data_in              (data_in),
        .data_valid_in        (data_valid_in),
        .transaction_valid_in (transaction_valid_in),
        .regs_out             (a_regs),
        .update_out           (a_upd),
        .busy_out             (a_busy),
        .addr_err_out         (a_err)
    );

    spi_reg_bank #(.NUM_REGS(128)) dut_b (
        .clk_in               (clk_in),
        .reset_in             (reset_in),
        .data_in              (data_in),
        .data_valid_in        (data_valid_in),
        .transaction_valid_in (transaction_valid_in),
        .regs_out             (b_regs),
        .update_out           (b_upd),
        .busy_out             (b_busy),
        .addr_err_out         (b_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        data_in       = b;
        data_valid_in = 1'b1;
        tick();
        data_valid_in = 1'b0;
        data_in       = 8'h00;
    endtask

    initial begin
        reset_in             = 1'b1;
        data_in              = 8'h00;
        data_valid_in        = 1'b0;
        transaction_valid_in = 1'b0;
        exp_a                = '0;
        tick();
        tick();
        reset_in = 1'b0;

        check("rst_regs", a_regs, '0);
        check("rst_upd",  a_upd,  1'b0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_err",  a_err,  1'b0);

        // Auto-increment burst to regs 2..4.
        transaction_valid_in = 1'b1;
        tick();
        check("t1_busy", a_busy, 1'b1);
        send(8'h82);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        check("t1_pre_regs", a_regs, '0);
        check("t1_pre_upd",  a_upd,  1'b0);
        transaction_valid_in = 1'b0;
        tick();
        exp_a[16 +: 8] = 8'h11;
        exp_a[24 +: 8] = 8'h22;
        exp_a[32 +: 8] = 8'h33;
        check("t1_regs", a_regs, exp_a);
        check("t1_upd",  a_upd,  1'b1);
        check("t1_idle", a_busy, 1'b0);
        tick();
        check("t1_upd_off", a_upd,  1'b0);
        check("t1_hold",    a_regs, exp_a);

        // No increment: last byte to reg 5 wins.
        transaction_valid_in = 1'b1;
        tick();
        send(8'h05);
        send(8'hAA);
        send(8'hBB);
        transaction_valid_in = 1'b0;
        tick();
        exp_a[40 +: 8] = 8'hBB;
        check("t2_regs", a_regs, exp_a);
        check("t2_reg4", a_regs[39:32], 8'h33);
        check("t2_reg6", a_regs[55:48], 8'h00);
        check("t2_upd",  a_upd, 1'b1);
        tick();
        check("t2_upd_off", a_upd, 1'b0);

        // Overflow past reg 15: two bytes land, two are dropped.
        transaction_valid_in = 1'b1;
        tick();
        send(8'h8E);
        send(8'h01);
        send(8'h02);
        check("t3_err_before", a_err, 1'b0);
        send(8'h03);
        check("t3_err_set", a_err, 1'b1);
        send(8'h04);
        transaction_valid_in = 1'b0;
        tick();
        exp_a[112 +: 8] = 8'h01;
        exp_a[120 +: 8] = 8'h02;
        check("t3_regs", a_regs, exp_a);
        check("t3_upd",  a_upd,  1'b1);
        check("t3_err",  a_err,  1'b1);
        tick();
        tick();
        check("t3_err_sticky", a_err,  1'b1);
        check("t3_idle_busy",  a_busy, 1'b0);

        // Empty transaction: error clears on the new assert, no commit.
        transaction_valid_in = 1'b1;
        tick();
        check("t4_err_clr", a_err,  1'b0);
        check("t4_busy",    a_busy, 1'b1);
        tick();
        tick();
        transaction_valid_in = 1'b0;
        tick();
        check("t4_upd",  a_upd,  1'b0);
        check("t4_busy_off", a_busy, 1'b0);
        check("t4_regs", a_regs, exp_a);
        tick();
        check("t4_upd_late", a_upd, 1'b0);

        // Command byte only.
        transaction_valid_in = 1'b1;
        tick();
        send(8'h83);
        transaction_valid_in = 1'b0;
        tick();
        check("t4c_upd", a_upd, 1'b0);
        tick();
        check("t4c_upd_late", a_upd,  1'b0);
        check("t4c_regs",     a_regs, exp_a);

        // Reset in the middle of a dirty transaction.
        transaction_valid_in = 1'b1;
        tick();
        send(8'h80);
        send(8'h55);
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        exp_a    = '0;
        check("t5_rst_regs", a_regs, exp_a);
        check("t5_rst_busy", a_busy, 1'b0);
        check("t5_rst_upd",  a_upd,  1'b0);
        tick();
        check("t5_reenter", a_busy, 1'b1);
        transaction_valid_in = 1'b0;
        tick();
        check("t5_upd",  a_upd,  1'b0);
        check("t5_regs", a_regs, exp_a);
        tick();
        check("t5_upd_late", a_upd, 1'b0);
        transaction_valid_in = 1'b1;
        tick();
        send(8'h80);
        send(8'h66);
        transaction_valid_in = 1'b0;
        tick();
        exp_a[7:0] = 8'h66;
        check("t5_full_regs", a_regs, exp_a);
        check("t5_full_upd",  a_upd,  1'b1);

        // 128-register instance: pointer wrap 127 -> 0, discard on the end cycle.
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        check("t6_rst", |b_regs, 1'b0);
        transaction_valid_in = 1'b1;
        tick();
        send(8'hFF);
        send(8'h77);
        send(8'h88);
        data_in              = 8'h99;
        data_valid_in        = 1'b1;
        transaction_valid_in = 1'b0;
        tick();
        data_valid_in = 1'b0;
        data_in       = 8'h00;
        check("t6_reg127", b_regs[1023:1016], 8'h77);
        check("t6_reg0",   b_regs[7:0],       8'h88);
        check("t6_reg1",   b_regs[15:8],      8'h00);
        check("t6_upd",    b_upd,             1'b1);

        // Immediate restart right after the commit cycle.
        transaction_valid_in = 1'b1;
        tick();
        check("t6_restart_busy", b_busy, 1'b1);
        check("t6_upd_off",      b_upd,  1'b0);
        send(8'h82);
        send(8'h5A);
        transaction_valid_in = 1'b0;
        tick();
        check("t6b_reg2",   b_regs[23:16],     8'h5A);
        check("t6b_reg1",   b_regs[15:8],      8'h00);
        check("t6b_reg0",   b_regs[7:0],       8'h88);
        check("t6b_reg127", b_regs[1023:1016], 8'h77);
        check("t6b_mid",    |b_regs[1015:24],  1'b0);
        check("t6b_upd",    b_upd,             1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
